intr_ctrl: RTL and testbench

- CPU-side interrupt controller; the receiving end of the IO memory's int_r/int_ack request handshake.
- Synchronises int_r, gates it with the interrupt-enable flag (SETIE/CLRIE), and accepts the request only at an instruction boundary.
- On acceptance: returns int_ack to the IO block, saves the return PC into EPC, and tells the control unit to vector to the ISR.
- Sits between the IO memory and the MIPS control unit/PC-select logic.

---
 rtl/intr_ctrl.sv | 121 ++++++++++++
 tb/tb_intr_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// CPU-side interrupt controller: synchronises the IO request, gates it with IE,
// and accepts it only at an instruction boundary.
module intr_ctrl #(
  parameter logic [31:0] ISR_VECTOR = 32'h0000_0100,
  parameter int unsigned ACK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_r,
  output logic        int_ack,
  input  logic        ie_set,
  input  logic        ie_clr,
  input  logic        reti,
  input  logic        inst_boundary,
  input  logic [31:0] pc_in,
  output logic        take_int,
  output logic [31:0] isr_addr,
  output logic [31:0] epc,
  output logic        ie,
  output logic        in_service
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sync1;
  logic             int_s;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic             req_ok;

  assign isr_addr = ISR_VECTOR;

  // Request is takeable; only honoured while IDLE (no nesting).
  assign req_ok = int_s & ie & armed & inst_boundary;

  // Two-flop synchroniser for the asynchronous request level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      int_s <= 1'b0;
    end else begin
      sync1 <= int_r;
      int_s <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_ok) state_nxt = ACK;
      ACK:     if (cnt == '0) state_nxt = SERVICE;
      SERVICE: if (reti) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational output: vector pulse in the accepting cycle.
  always_comb begin
    take_int = 1'b0;
    if (state == IDLE && req_ok) take_int = 1'b1;
  end

  // Registered datapath: ack, counter, EPC, IE, armed, in_service.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_ack    <= 1'b0;
      cnt        <= '0;
      epc        <= '0;
      ie         <= 1'b0;
      armed      <= 1'b1;
      in_service <= 1'b0;
    end else begin
      // Re-arm only once the synchronised request has been seen low.
      if (!int_s)        armed <= 1'b1;
      else if (take_int) armed <= 1'b0;

      if (take_int)                         ie <= 1'b0;
      else if (ie_clr)                      ie <= 1'b0;
      else if (ie_set)                      ie <= 1'b1;
      else if (state == SERVICE && reti)    ie <= 1'b1;

      case (state)
        IDLE: begin
          if (take_int) begin
            epc     <= pc_in;
            int_ack <= 1'b1;
            cnt     <= CNT_W'(ACK_CYCLES - 1);
          end
        end
        ACK: begin
          if (cnt == '0) begin
            int_ack    <= 1'b0;
            in_service <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SERVICE: begin
          if (reti) in_service <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed stimulus, expected EPC values
// queued at issue time and checked by a monitor on each take_int pulse.
module tb_intr_ctrl;

  logic        clk;
  logic        reset;
  logic        int_r;
  logic        int_ack;
  logic        ie_set;
  logic        ie_clr;
  logic        reti;
  logic        inst_boundary;
  logic [31:0] pc_in;
  logic        take_int;
  logic [31:0] isr_addr;
  logic [31:0] epc;
  logic        ie;
  logic        in_service;

  int total;
  int bad;
  int n_take;
  logic [31:0] exp_q[$];

  intr_ctrl #(.ISR_VECTOR(32'h0000_0100), .ACK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .int_r(int_r), .int_ack(int_ack),
    .ie_set(ie_set), .ie_clr(ie_clr), .reti(reti),
    .inst_boundary(inst_boundary), .pc_in(pc_in), .take_int(take_int),
    .isr_addr(isr_addr), .epc(epc), .ie(ie), .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_service(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_service === 1'b1) break;
    end
    chk(name, 32'(in_service), 32'd1);
  endtask

  // Leave the ISR and drop the request so the next test starts from IDLE.
  task automatic finish_isr();
    tick();
    reti = 1'b1;
    int_r = 1'b0;
    tick();
    reti = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor: every take_int pulse must match a queued EPC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (take_int === 1'b1) begin
        n_take++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_take: got take_int=1 expected none, pc_in=%h", pc_in);
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          chk("epc_after_take", epc, e);
          chk("ack_after_take", 32'(int_ack), 32'd1);
          chk("ie_after_take", 32'(ie), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ack_exp;
    logic [3:0] isv_exp;
    total = 0; bad = 0; n_take = 0;
    reset = 1'b1; int_r = 1'b0; ie_set = 1'b0; ie_clr = 1'b0; reti = 1'b0;
    inst_boundary = 1'b0; pc_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_int_ack", 32'(int_ack), 32'd0);
    chk("rst_take_int", 32'(take_int), 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_ie", 32'(ie), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("isr_addr", isr_addr, 32'h0000_0100);
    tick();
    reset = 1'b0;

    // Request held with IE off: nothing taken.
    int_r = 1'b1; inst_boundary = 1'b1; pc_in = 32'h0000_0040;
    repeat (50) tick();
    chk("ie_off_no_take", 32'(n_take), 32'd0);
    chk("ie_off_no_ack", 32'(int_ack), 32'd0);

    // Enable IE: accepted next cycle, ack for 2 cycles, then in_service.
    exp_q.push_back(32'h0000_0040);
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    ack_exp = 4'b0110;
    isv_exp = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] av;
      logic [3:0] sv;
      av = ack_exp;
      sv = isv_exp;
      @(negedge clk);
      if (i == 0) chk("take_pulse", 32'(take_int), 32'd1);
      chk($sformatf("ack_seq%0d", i), 32'(int_ack), 32'(av[i]));
      chk($sformatf("isv_seq%0d", i), 32'(in_service), 32'(sv[i]));
    end
    chk("take_count1", 32'(n_take), 32'd1);

    // reti with request still high: IE restored, no re-take.
    tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    repeat (10) tick();
    chk("reti_in_service", 32'(in_service), 32'd0);
    chk("reti_ie", 32'(ie), 32'd1);
    chk("no_retake", 32'(n_take), 32'd1);

    // Drop for 3 cycles, raise again: second acceptance.
    int_r = 1'b0;
    repeat (3) tick();
    exp_q.push_back(32'h0000_0080);
    pc_in = 32'h0000_0080;
    int_r = 1'b1;
    wait_service("second_service", 20);
    chk("take_count2", 32'(n_take), 32'd2);
    finish_isr();

    // Pending request held off by inst_boundary=0.
    inst_boundary = 1'b0;
    pc_in = 32'h0000_00B0;
    int_r = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("no_boundary%0d", i), 32'(take_int), 32'd0);
    end
    tick();
    exp_q.push_back(32'h0000_00C0);
    pc_in = 32'h0000_00C0;
    inst_boundary = 1'b1;
    @(negedge clk);
    chk("boundary_take", 32'(take_int), 32'd1);
    wait_service("third_service", 20);
    finish_isr();
    chk("take_count3", 32'(n_take), 32'd3);

    // ie_set and ie_clr together: clear wins. Then reti in IDLE is ignored.
    ie_set = 1'b1; ie_clr = 1'b1;
    tick();
    ie_set = 1'b0; ie_clr = 1'b0;
    chk("set_clr_ie", 32'(ie), 32'd0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    chk("idle_reti_ie", 32'(ie), 32'd0);
    chk("idle_reti_isv", 32'(in_service), 32'd0);
    chk("idle_reti_ack", 32'(int_ack), 32'd0);

    // Reset during ACK, then re-accept after synchroniser latency.
    int_r = 1'b1;
    pc_in = 32'h0000_0140;
    repeat (3) tick();
    exp_q.push_back(32'h0000_0140);
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_ack_rst_ack", 32'(int_ack), 32'd0);
    chk("mid_ack_rst_epc", epc, 32'd0);
    chk("mid_ack_rst_isv", 32'(in_service), 32'd0);
    repeat (2) tick();
    exp_q.push_back(32'h0000_0180);
    pc_in = 32'h0000_0180;
    reset = 1'b0;
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    @(negedge clk);
    chk("post_rst_lat1", 32'(take_int), 32'd0);
    @(negedge clk);
    chk("post_rst_lat2", 32'(take_int), 32'd1);
    wait_service("post_rst_service", 20);
    finish_isr();

    chk("final_take_count", 32'(n_take), 32'd5);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
